btb_predictor: RTL

- Direct-mapped branch target buffer with 2-bit saturating counters. It sits in the IF stage and predicts the next PC for the fetch address.
- It is trained by the EX stage using the resolved branch PC, the outcome, and the branch target latched by the ID/EX branch-target register (address_EX).
- The fetch PC mux consumes pred_taken_IF and pred_target_IF.

---
 rtl/btb_predictor.sv | 71 +++++++
 1 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational IF-stage lookup; single EX-stage training port, no write-to-read bypass.
module btb_predictor #(
    parameter  int ENTRIES = 16,
    localparam int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_IF,
    output logic        hit_IF,
    output logic        pred_taken_IF,
    output logic [31:0] pred_target_IF,
    input  logic        upd_en_EX,
    input  logic [31:0] pc_EX,
    input  logic        taken_EX,
    input  logic [31:0] address_EX
);

    localparam int TAG_W = 32 - 2 - INDEX_W;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic [INDEX_W-1:0] w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic [INDEX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_ex_hit;

    assign w_if_idx = pc_IF[INDEX_W+1:2];
    assign w_if_tag = pc_IF[31:INDEX_W+2];
    assign w_ex_idx = pc_EX[INDEX_W+1:2];
    assign w_ex_tag = pc_EX[31:INDEX_W+2];

    // Lookup sees only registered state, so an update this cycle is visible next cycle.
    assign hit_IF         = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken_IF  = hit_IF && r_ctr[w_if_idx][1];
    assign pred_target_IF = pred_taken_IF ? r_target[w_if_idx] : (pc_IF + 32'd4);

    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (upd_en_EX) begin
            if (w_ex_hit) begin
                if (taken_EX) begin
                    if (r_ctr[w_ex_idx] != 2'b11)
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    r_target[w_ex_idx] <= address_EX;
                end else if (r_ctr[w_ex_idx] != 2'b00) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (taken_EX) begin
                // Taken miss replaces whatever occupied this index.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= address_EX;
                r_ctr[w_ex_idx]    <= 2'b10;
            end
        end
    end

endmodule
